// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-configuration sequencer.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInitWait,
        StLoad,
        StIssue,
        StWaitDone,
        StGap,
        StDone,
        StFail
    } cfg_state_e;

    localparam logic [6:0]  DefDevAddr = 7'h3C;
    localparam int unsigned EntryW     = 16;

    // Command entry: register address in [15:8], write data in [7:0].
    typedef logic [EntryW-1:0] cmd_entry_t;

    function automatic int unsigned cnt_w(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Register-write command table with a registered one-cycle read port.
module i2c_cfg_rom
    import i2c_pkg::*;
#(
    parameter int unsigned CMD_NUM = 16
) (
    input  logic       sys_clk,
    input  logic [7:0] index,
    output cmd_entry_t entry
);

    cmd_entry_t rom_d;

    // Indices at or beyond CMD_NUM read as zero.
    always_comb begin
        rom_d = '0;
        if (32'(index) < CMD_NUM) begin
            case (index)
                8'd0:    rom_d = 16'h10AE;
                8'd1:    rom_d = 16'h11D5;
                8'd2:    rom_d = 16'h1280;
                8'd3:    rom_d = 16'h13A8;
                8'd4:    rom_d = 16'h143F;
                8'd5:    rom_d = 16'h15D3;
                8'd6:    rom_d = 16'h1600;
                8'd7:    rom_d = 16'h1740;
                8'd8:    rom_d = 16'h188D;
                8'd9:    rom_d = 16'h1914;
                8'd10:   rom_d = 16'h1A20;
                8'd11:   rom_d = 16'h1B00;
                8'd12:   rom_d = 16'h1CA1;
                8'd13:   rom_d = 16'h1DC8;
                8'd14:   rom_d = 16'h1E81;
                8'd15:   rom_d = 16'h1FAF;
                default: rom_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        entry <= rom_d;
    end

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks the command table, issuing one I2C register write per entry with
// start delay, inter-command gap, timeout and bounded retry on NACK.
module i2c_cfg_seq
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter logic [6:0]  DEV_ADDR     = DefDevAddr,
    parameter int unsigned CMD_NUM      = 16,
    parameter int unsigned INIT_DLY_CYC = 50_000,
    parameter int unsigned GAP_CYC      = 1_000,
    parameter int unsigned TIMEOUT_CYC  = 100_000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic       i2c_done,
    input  logic       i2c_ack_err,
    output logic       w_enable,
    output logic       r_enable,
    output logic [7:0] slave_addr,
    output logic [7:0] i2c_addr,
    output logic [7:0] i2c_data_w,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [7:0] cmd_idx
);

    localparam int unsigned InitW  = cnt_w(INIT_DLY_CYC);
    localparam int unsigned TmoW   = cnt_w(TIMEOUT_CYC);
    localparam int unsigned GapW   = cnt_w(GAP_CYC);
    localparam int unsigned RetryW = cnt_w(MAX_RETRY + 1);

    localparam logic [InitW-1:0]  InitLast = InitW'(INIT_DLY_CYC - 1);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYC - 1);
    localparam logic [GapW-1:0]   GapLast  = GapW'(GAP_CYC - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
    localparam logic [7:0]        LastIdx  = 8'(CMD_NUM - 1);

    if (CLK_FREQ == 0 || CMD_NUM == 0 || CMD_NUM > 256 || INIT_DLY_CYC == 0 ||
        GAP_CYC == 0 || TIMEOUT_CYC == 0) begin : g_bad_param
        $error("i2c_cfg_seq: illegal parameter value");
    end

    cfg_state_e        state_q, state_d;
    logic [7:0]        cmd_idx_q, cmd_idx_d;
    logic [InitW-1:0]  init_cnt_q, init_cnt_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [RetryW-1:0] retry_cnt_q, retry_cnt_d;
    logic              retry_pend_q, retry_pend_d;
    logic              ld_wait_q, ld_wait_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              attempt_fail;
    cmd_entry_t        rom_entry;

    i2c_cfg_rom #(
        .CMD_NUM(CMD_NUM)
    ) u_rom (
        .sys_clk(sys_clk),
        .index  (cmd_idx_q),
        .entry  (rom_entry)
    );

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cmd_idx_q    <= '0;
            init_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            retry_pend_q <= 1'b0;
            ld_wait_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_idx_q    <= cmd_idx_d;
            init_cnt_q   <= init_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            retry_pend_q <= retry_pend_d;
            ld_wait_q    <= ld_wait_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Counters idle at zero outside their own state, so entry needs no explicit clear.
    always_comb begin
        state_d      = state_q;
        cmd_idx_d    = cmd_idx_q;
        init_cnt_d   = '0;
        tmo_cnt_d    = '0;
        gap_cnt_d    = '0;
        retry_cnt_d  = retry_cnt_q;
        retry_pend_d = retry_pend_q;
        ld_wait_d    = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        done_d       = done_q;
        err_d        = err_q;
        attempt_fail = 1'b0;

        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (cfg_start) begin
                    state_d      = StInitWait;
                    cmd_idx_d    = '0;
                    retry_cnt_d  = '0;
                    retry_pend_d = 1'b0;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                end
            end
            StInitWait: begin
                if (init_cnt_q == InitLast) state_d = StLoad;
                else                        init_cnt_d = init_cnt_q + 1'b1;
            end
            StLoad: begin
                // First cycle lets the ROM capture cmd_idx; second latches its output.
                if (!ld_wait_q) begin
                    ld_wait_d = 1'b1;
                end else begin
                    addr_d  = rom_entry[15:8];
                    data_d  = rom_entry[7:0];
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWaitDone;
            StWaitDone: begin
                if (i2c_done) begin
                    if (!i2c_ack_err) begin
                        retry_cnt_d  = '0;
                        retry_pend_d = 1'b0;
                        state_d      = StGap;
                    end else begin
                        attempt_fail = 1'b1;
                    end
                end else if (tmo_cnt_q == TmoLast) begin
                    attempt_fail = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
                if (attempt_fail) begin
                    if (retry_cnt_q < RetryMax) begin
                        retry_cnt_d  = retry_cnt_q + 1'b1;
                        retry_pend_d = 1'b1;
                        state_d      = StGap;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StFail;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q != GapLast) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end else if (retry_pend_q) begin
                    retry_pend_d = 1'b0;
                    state_d      = StLoad;
                end else if (cmd_idx_q == LastIdx) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cmd_idx_d = cmd_idx_q + 8'd1;
                    state_d   = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign w_enable   = (state_q == StIssue);
    assign r_enable   = 1'b0;
    assign slave_addr = {DEV_ADDR, 1'b0};
    assign i2c_addr   = addr_q;
    assign i2c_data_w = data_q;
    assign cfg_busy   = !(state_q == StIdle || state_q == StDone || state_q == StFail);
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign cmd_idx    = cmd_idx_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Directed self-checking bench for i2c_cfg_seq with a small four-entry run.
module tb_i2c_cfg_seq;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic       i2c_done;
    logic       i2c_ack_err;
    logic       w_enable;
    logic       r_enable;
    logic [7:0] slave_addr;
    logic [7:0] i2c_addr;
    logic [7:0] i2c_data_w;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [7:0] cmd_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_lat;

    int iss_idx[$];
    int iss_addr[$];
    int iss_data[$];
    int iss_cyc[$];
    int exp_seq[$];

    logic [7:0] exp_addr [0:3];
    logic [7:0] exp_data [0:3];

    i2c_cfg_seq #(
        .CLK_FREQ    (50_000_000),
        .DEV_ADDR    (7'h3C),
        .CMD_NUM     (4),
        .INIT_DLY_CYC(10),
        .GAP_CYC     (5),
        .TIMEOUT_CYC (50),
        .MAX_RETRY   (2)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .i2c_done   (i2c_done),
        .i2c_ack_err(i2c_ack_err),
        .w_enable   (w_enable),
        .r_enable   (r_enable),
        .slave_addr (slave_addr),
        .i2c_addr   (i2c_addr),
        .i2c_data_w (i2c_data_w),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .cmd_idx    (cmd_idx)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    // Runs one configuration; the bench plays the I2C master answering after resp_dly cycles.
    task automatic run_seq(input int resp_dly, input int nack_idx, input int silent_idx,
                           input int start_after, input int rst_after);
        int cd = 0;
        bit nack_now = 1'b0;
        bit nacked = 1'b0;
        int sc = 0;
        int rc = 0;
        int c0;
        bit fin = 1'b0;
        bit did_rst = 1'b0;
        iss_idx.delete();
        iss_addr.delete();
        iss_data.delete();
        iss_cyc.delete();
        first_lat = -1;
        c0 = cyc;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (!cfg_busy) begin
                fin = 1'b1;
                break;
            end
            i2c_done    = 1'b0;
            i2c_ack_err = 1'b0;
            cfg_start   = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    i2c_done    = 1'b1;
                    i2c_ack_err = nack_now;
                end
            end
            if (sc > 0) begin
                sc--;
                if (sc == 0) cfg_start = 1'b1;
            end
            if (rc > 0) begin
                rc--;
                if (rc == 0) begin
                    rst_n    = 1'b0;
                    i2c_done = 1'b0;
                    step();
                    rst_n   = 1'b1;
                    did_rst = 1'b1;
                    break;
                end
            end
            if (w_enable) begin
                if (iss_cyc.size() == 0) first_lat = cyc - c0;
                iss_idx.push_back(int'(cmd_idx));
                iss_addr.push_back(int'(i2c_addr));
                iss_data.push_back(int'(i2c_data_w));
                iss_cyc.push_back(cyc);
                if (int'(cmd_idx) == silent_idx) begin
                    cd = 0;
                end else begin
                    cd       = resp_dly;
                    nack_now = (int'(cmd_idx) == nack_idx) && !nacked;
                    if (nack_now) nacked = 1'b1;
                end
                if (iss_idx.size() == start_after) sc = 5;
                if (iss_idx.size() == rst_after) rc = 5;
            end
            step();
        end
        i2c_done    = 1'b0;
        i2c_ack_err = 1'b0;
        cfg_start   = 1'b0;
        if (!fin && !did_rst) check_eq("run_cycle_budget", 32'd0, 32'd1);
    endtask

    task automatic check_issues(input string tag);
        check_eq({tag, "_count"}, iss_idx.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < iss_idx.size(); i++) begin
            check_eq($sformatf("%s_idx%0d", tag, i), iss_idx[i], exp_seq[i]);
            check_eq($sformatf("%s_addr%0d", tag, i), iss_addr[i], exp_addr[exp_seq[i]]);
            check_eq($sformatf("%s_data%0d", tag, i), iss_data[i], exp_data[exp_seq[i]]);
        end
    endtask

    task automatic check_end(input string tag, input logic done_e, input logic err_e,
                             input logic [7:0] idx_e);
        check_eq({tag, "_done"}, cfg_done, done_e);
        check_eq({tag, "_err"}, cfg_err, err_e);
        check_eq({tag, "_idx"}, cmd_idx, idx_e);
        check_eq({tag, "_busy"}, cfg_busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wen"}, w_enable, 1'b0);
        check_eq({tag, "_ren"}, r_enable, 1'b0);
        check_eq({tag, "_busy"}, cfg_busy, 1'b0);
        check_eq({tag, "_done"}, cfg_done, 1'b0);
        check_eq({tag, "_err"}, cfg_err, 1'b0);
        check_eq({tag, "_idx"}, cmd_idx, 8'h00);
        check_eq({tag, "_addr"}, i2c_addr, 8'h00);
        check_eq({tag, "_data"}, i2c_data_w, 8'h00);
        check_eq({tag, "_slave"}, slave_addr, 8'h78);
    endtask

    initial begin
        int wen_seen;
        int busy_seen;
        exp_addr[0] = 8'h10; exp_data[0] = 8'hAE;
        exp_addr[1] = 8'h11; exp_data[1] = 8'hD5;
        exp_addr[2] = 8'h12; exp_data[2] = 8'h80;
        exp_addr[3] = 8'h13; exp_data[3] = 8'hA8;

        rst_n       = 1'b0;
        cfg_start   = 1'b0;
        i2c_done    = 1'b0;
        i2c_ack_err = 1'b0;
        repeat (3) step();
        check_reset_outputs("por");
        rst_n = 1'b1;
        step();

        // All commands ACKed 20 cycles after w_enable.
        run_seq(20, -1, -1, -1, -1);
        exp_seq = '{0, 1, 2, 3};
        check_issues("ack");
        check_end("ack", 1'b1, 1'b0, 8'd3);
        // INIT 10 + LOAD 2 + ISSUE edge = 13; ACK period 20 + GAP 5 + LOAD 2 + ISSUE 1 = 28.
        check_eq("ack_first_latency", first_lat, 13);
        if (iss_cyc.size() >= 2) check_eq("ack_interval", iss_cyc[1] - iss_cyc[0], 28);

        // i2c_done lands on the timeout cycle: success, no retry.
        run_seq(50, -1, -1, -1, -1);
        check_issues("coinc");
        check_end("coinc", 1'b1, 1'b0, 8'd3);

        // Single NACK on command 1, then ACK.
        run_seq(20, 1, -1, -1, -1);
        exp_seq = '{0, 1, 1, 2, 3};
        check_issues("nack");
        check_end("nack", 1'b1, 1'b0, 8'd3);

        // Command 2 never answered: three issues, then FAIL.
        run_seq(20, -1, 2, -1, -1);
        exp_seq = '{0, 1, 2, 2, 2};
        check_issues("silent");
        check_end("silent", 1'b0, 1'b1, 8'd2);
        // Timeout 50 + GAP 5 + LOAD 2 + ISSUE 1 = 58 between retries.
        if (iss_cyc.size() >= 5) begin
            check_eq("silent_retry_gap1", iss_cyc[3] - iss_cyc[2], 58);
            check_eq("silent_retry_gap2", iss_cyc[4] - iss_cyc[3], 58);
        end

        // cfg_start while busy in WAIT_DONE of command 1 is ignored.
        run_seq(20, -1, -1, 2, -1);
        exp_seq = '{0, 1, 2, 3};
        check_issues("busy_start");
        check_end("busy_start", 1'b1, 1'b0, 8'd3);

        // One-cycle reset in WAIT_DONE of command 1.
        run_seq(20, -1, -1, -1, 2);
        check_reset_outputs("midrst");
        wen_seen  = 0;
        busy_seen = 0;
        i2c_done  = 1'b1;
        step();
        i2c_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (w_enable) wen_seen++;
            if (cfg_busy) busy_seen++;
            step();
        end
        check_eq("midrst_no_reissue", wen_seen, 0);
        check_eq("midrst_idle", busy_seen, 0);

        run_seq(20, -1, -1, -1, -1);
        exp_seq = '{0, 1, 2, 3};
        check_issues("restart");
        check_end("restart", 1'b1, 1'b0, 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
